cpu_ctrl: RTL and testbench
===========================

CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: data, operand and program-counter width.
REQ-002 Parameter IWIDTH, default 5: opcode width; ALU function field is IWIDTH-1 bits.
REQ-003 Parameter STACK_DEPTH, default 4: return-stack entries.
REQ-004 CLK  in  1: single clock, rising edge.
REQ-005 RST  in  1: reset, synchronous, active-high.
REQ-006 EN  in  1: run enable; 0 = stall.
REQ-007 INSTR  in  IWIDTH+2+WIDTH: {OPC, MODE[1:0], OPERAND} from program memory, valid the same cycle as PC.
REQ-008 Z  in  1: registered zero flag from the datapath.
REQ-009 PC  out  WIDTH: program-memory address.
REQ-010 REG_F_SEL  out  4, EN_REG_F  out  1: register-file select and write enable.
REQ-011 D_MEM_ADDR  out  WIDTH, D_MEM_ADDR_MODE  out  1, EN_D_MEM  out  1: data-memory address, address source, write enable.
REQ-012 IN_B_SEL  out  2, IMM  out  WIDTH: ALU B source select and immediate value.
REQ-013 ALU_OUT  out  IWIDTH-1, EN_ACC  out  1: ALU function code and accumulator load.
REQ-014 HALTED  out  1, ERR  out  1: halt status and stack-fault status.

Function
REQ-015 Decode is combinational from INSTR and state; PC and stack update on the rising edge of CLK (one instruction per cycle).
REQ-016 IMM, D_MEM_ADDR and REG_F_SEL (OPERAND[3:0]) always follow OPERAND; IN_B_SEL = MODE with MODE=11 mapped to 10; D_MEM_ADDR_MODE = MODE[0] when MODE[1]=1, else 0.
REQ-017 OPC[4]=0: ALU op; ALU_OUT = OPC[3:0], EN_ACC=1, PC+1.
REQ-018 10000 NOP: PC+1. 10001 STR: EN_REG_F=1, PC+1. 10010 STM: EN_D_MEM=1, PC+1.
REQ-019 10011 JMP: PC=OPERAND. 10100 JZ: PC=OPERAND if Z=1, else PC+1. 10101 JNZ: PC=OPERAND if Z=0, else PC+1.
REQ-020 10110 CALL: push PC+1, PC=OPERAND. 10111 RET: PC=pop.
REQ-021 11000 HALT: enter HALT; PC holds. Other OPC[4]=1 codes execute as NOP.
REQ-022 States RUN and HALT; only RST leaves HALT. In HALT, or when EN=0, EN_REG_F, EN_D_MEM and EN_ACC are 0, and PC and stack hold.
REQ-023 PC+1 wraps from 2^WIDTH-1 to 0.
REQ-024 CALL with the stack full, or RET with the stack empty: no push/pop, ERR=1, enter HALT; PC holds.
REQ-025 RST has priority over EN and all opcodes in the same cycle.

Reset
REQ-026 On RST: PC=0, state RUN, stack empty, ERR=0, HALTED=0.
REQ-027 RST mid-program discards stack contents; the next cycle fetches address 0.
REQ-028 During the RST cycle, all write enables (EN_REG_F, EN_D_MEM, EN_ACC) are 0.

Structure
REQ-029 Opcode and MODE encodings live in a shared cpu package used by cpu_ctrl and the assembler bench.
REQ-030 The return stack is sub-module cpu_ret_stack: WIDTH x STACK_DEPTH, with PUSH, POP, FULL and EMPTY.

Verification
REQ-031 RST, then ALU op 00001 MODE=00 OPERAND=0x05 -> EN_ACC=1, ALU_OUT=0001, IN_B_SEL=00, IMM=0x05; PC 0 -> 1.
REQ-032 JZ 0x40 with Z=1 -> PC=0x40; JZ 0x40 with Z=0 at PC=0x10 -> PC=0x11.
REQ-033 CALL 0x80 at PC=0x03, then RET at 0x80 -> PC 0x80, then 0x04; stack empty afterwards.
REQ-034 Five nested CALLs (depth 4) -> fifth: ERR=1, HALTED=1, PC holds; write enables 0 until RST.
REQ-035 STM MODE=11 OPERAND=0x02 -> EN_D_MEM=1, D_MEM_ADDR_MODE=1, IN_B_SEL=10; EN=0 on the same op -> EN_D_MEM=0, PC holds.
REQ-036 PC=0xFF executing NOP -> PC=0x00; HALT, then RST -> PC=0, HALTED=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_ctrl_pkg
// Brief  : Opcode, MODE and state encodings shared by the controller and bench
// Rev    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    // Control opcodes: OPC MSB = 1, these are the low IWIDTH-1 bits
    localparam logic [3:0] C_CTL_NOP  = 4'h0;
    localparam logic [3:0] C_CTL_STR  = 4'h1;
    localparam logic [3:0] C_CTL_STM  = 4'h2;
    localparam logic [3:0] C_CTL_JMP  = 4'h3;
    localparam logic [3:0] C_CTL_JZ   = 4'h4;
    localparam logic [3:0] C_CTL_JNZ  = 4'h5;
    localparam logic [3:0] C_CTL_CALL = 4'h6;
    localparam logic [3:0] C_CTL_RET  = 4'h7;
    localparam logic [3:0] C_CTL_HALT = 4'h8;

    localparam logic [1:0] C_MODE_IMM  = 2'b00;
    localparam logic [1:0] C_MODE_REG  = 2'b01;
    localparam logic [1:0] C_MODE_MEM  = 2'b10;
    localparam logic [1:0] C_MODE_MEMI = 2'b11;

    localparam logic [0:0] C_ST_RUN  = 1'b0;
    localparam logic [0:0] C_ST_HALT = 1'b1;

    // Both memory modes feed the ALU B input from the memory path
    function automatic logic [1:0] mode_to_bsel(input logic [1:0] mode);
        return (mode == C_MODE_MEMI) ? C_MODE_MEM : mode;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_ret_stack.sv
`default_nettype none
// ============================================================================
// Module : cpu_ret_stack
// Brief  : LIFO return-address stack with full/empty status
// Rev    : 1.0 - initial release
// ============================================================================
module cpu_ret_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_full,
    output logic             o_empty
);

    localparam int C_CW = $clog2(DEPTH + 1);
    localparam int C_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [C_CW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [C_AW-1:0]  w_wr_idx;
    logic [C_AW-1:0]  w_rd_idx;

    assign w_wr_idx = cnt_q[C_AW-1:0];
    assign w_rd_idx = C_AW'(cnt_q - 1'b1);
    assign o_full   = (cnt_q == C_CW'(DEPTH));
    assign o_empty  = (cnt_q == '0);
    assign o_top    = mem_q[w_rd_idx];

    always_comb begin
        cnt_d = cnt_q;
        mem_d = mem_q;
        if (i_push && !o_full) begin
            mem_d[w_wr_idx] = i_data;
            cnt_d           = cnt_q + 1'b1;
        end else if (i_pop && !o_empty) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/cpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module : cpu_ctrl
// Brief  : Single-cycle instruction decoder, PC sequencer and halt/fault FSM
// Rev    : 1.0 - initial release
// ============================================================================
module cpu_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int IWIDTH      = 5,
    parameter int STACK_DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     EN,
    input  logic [IWIDTH+WIDTH+1:0]  INSTR,
    input  logic                     Z,
    output logic [WIDTH-1:0]         PC,
    output logic [3:0]               REG_F_SEL,
    output logic                     EN_REG_F,
    output logic [WIDTH-1:0]         D_MEM_ADDR,
    output logic                     D_MEM_ADDR_MODE,
    output logic                     EN_D_MEM,
    output logic [1:0]               IN_B_SEL,
    output logic [WIDTH-1:0]         IMM,
    output logic [IWIDTH-2:0]        ALU_OUT,
    output logic                     EN_ACC,
    output logic                     HALTED,
    output logic                     ERR
);

    localparam int C_FW = IWIDTH - 1;

    logic [0:0]        state_q, state_d;
    logic [WIDTH-1:0]  pc_q, pc_d;
    logic              err_q, err_d;

    logic [IWIDTH-1:0] w_opc;
    logic [1:0]        w_mode;
    logic [WIDTH-1:0]  w_operand;
    logic [C_FW-1:0]   w_func;
    logic              w_is_ctl;
    logic              w_run;
    logic [WIDTH-1:0]  w_pc_inc;
    logic              w_push, w_pop;
    logic [WIDTH-1:0]  w_stk_top;
    logic              w_stk_full, w_stk_empty;

    assign w_opc     = INSTR[IWIDTH+WIDTH+1:WIDTH+2];
    assign w_mode    = INSTR[WIDTH+1:WIDTH];
    assign w_operand = INSTR[WIDTH-1:0];
    assign w_func    = w_opc[C_FW-1:0];
    assign w_is_ctl  = w_opc[IWIDTH-1];
    assign w_run     = (state_q == C_ST_RUN) && EN;
    assign w_pc_inc  = pc_q + 1'b1;

    cpu_ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk     (CLK),
        .rst     (RST),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pc_inc),
        .o_top   (w_stk_top),
        .o_full  (w_stk_full),
        .o_empty (w_stk_empty)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= C_ST_RUN;
            pc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        w_push  = 1'b0;
        w_pop   = 1'b0;
        if (w_run) begin
            if (!w_is_ctl) begin
                pc_d = w_pc_inc;
            end else begin
                case (w_func)
                    C_FW'(C_CTL_JMP):  pc_d = w_operand;
                    C_FW'(C_CTL_JZ):   pc_d = Z ? w_operand : w_pc_inc;
                    C_FW'(C_CTL_JNZ):  pc_d = Z ? w_pc_inc : w_operand;
                    C_FW'(C_CTL_CALL): begin
                        if (w_stk_full) begin
                            err_d   = 1'b1;
                            state_d = C_ST_HALT;
                        end else begin
                            w_push = 1'b1;
                            pc_d   = w_operand;
                        end
                    end
                    C_FW'(C_CTL_RET): begin
                        if (w_stk_empty) begin
                            err_d   = 1'b1;
                            state_d = C_ST_HALT;
                        end else begin
                            w_pop = 1'b1;
                            pc_d  = w_stk_top;
                        end
                    end
                    C_FW'(C_CTL_HALT): state_d = C_ST_HALT;
                    default:           pc_d = w_pc_inc;
                endcase
            end
        end
    end

    // Write enables are suppressed while reset is asserted, halted or stalled
    always_comb begin
        EN_ACC   = 1'b0;
        EN_REG_F = 1'b0;
        EN_D_MEM = 1'b0;
        if (w_run && !RST) begin
            if (!w_is_ctl) begin
                EN_ACC = 1'b1;
            end else if (w_func == C_FW'(C_CTL_STR)) begin
                EN_REG_F = 1'b1;
            end else if (w_func == C_FW'(C_CTL_STM)) begin
                EN_D_MEM = 1'b1;
            end
        end
    end

    assign PC              = pc_q;
    assign HALTED          = (state_q == C_ST_HALT);
    assign ERR             = err_q;
    assign ALU_OUT         = w_func;
    assign IMM             = w_operand;
    assign D_MEM_ADDR      = w_operand;
    assign REG_F_SEL       = w_operand[3:0];
    assign IN_B_SEL        = mode_to_bsel(w_mode);
    assign D_MEM_ADDR_MODE = w_mode[1] & w_mode[0];

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_cpu_ctrl
// Brief  : Directed plus randomized checks of cpu_ctrl against a queue model
// Rev    : 1.0 - initial release
// ============================================================================
module tb_cpu_ctrl;
    import cpu_ctrl_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        EN  = 1'b0;
    logic [14:0] INSTR = '0;
    logic        Z   = 1'b0;
    logic [7:0]  PC;
    logic [3:0]  REG_F_SEL;
    logic        EN_REG_F;
    logic [7:0]  D_MEM_ADDR;
    logic        D_MEM_ADDR_MODE;
    logic        EN_D_MEM;
    logic [1:0]  IN_B_SEL;
    logic [7:0]  IMM;
    logic [3:0]  ALU_OUT;
    logic        EN_ACC;
    logic        HALTED;
    logic        ERR;

    int n_cmp  = 0;
    int n_fail = 0;

    int m_pc     = 0;
    bit m_halted = 1'b0;
    bit m_err    = 1'b0;
    int m_stk[$];

    cpu_ctrl #(.WIDTH(8), .IWIDTH(5), .STACK_DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .INSTR(INSTR), .Z(Z),
        .PC(PC), .REG_F_SEL(REG_F_SEL), .EN_REG_F(EN_REG_F),
        .D_MEM_ADDR(D_MEM_ADDR), .D_MEM_ADDR_MODE(D_MEM_ADDR_MODE),
        .EN_D_MEM(EN_D_MEM), .IN_B_SEL(IN_B_SEL), .IMM(IMM),
        .ALU_OUT(ALU_OUT), .EN_ACC(EN_ACC), .HALTED(HALTED), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] ctl(input logic [3:0] code);
        return {1'b1, code};
    endfunction

    // One instruction cycle: drive, check decode against the model, advance model
    task automatic step(input logic [4:0] opc, input logic [1:0] mode, input logic [7:0] opnd,
                        input logic z, input logic en, input logic rst);
        bit wr;
        int nxt;
        int op;
        @(negedge CLK);
        INSTR = {opc, mode, opnd};
        Z     = z;
        EN    = en;
        RST   = rst;
        #1;
        op = int'(opc);
        wr = !rst && en && !m_halted;
        chk("pc", 32'(PC), m_pc);
        chk("halted", 32'(HALTED), 32'(m_halted));
        chk("err", 32'(ERR), 32'(m_err));
        chk("en_acc", 32'(EN_ACC), 32'(wr && op < 16));
        chk("en_reg_f", 32'(EN_REG_F), 32'(wr && op == 17));
        chk("en_d_mem", 32'(EN_D_MEM), 32'(wr && op == 18));
        chk("imm", 32'(IMM), 32'(opnd));
        chk("d_mem_addr", 32'(D_MEM_ADDR), 32'(opnd));
        chk("reg_f_sel", 32'(REG_F_SEL), 32'(opnd % 16));
        chk("in_b_sel", 32'(IN_B_SEL), (mode == 2'd3) ? 32'd2 : 32'(mode));
        chk("d_mem_addr_mode", 32'(D_MEM_ADDR_MODE), 32'(mode == 2'd3));
        if (op < 16) chk("alu_out", 32'(ALU_OUT), op);

        if (rst) begin
            m_pc = 0; m_stk.delete(); m_halted = 1'b0; m_err = 1'b0;
        end else if (en && !m_halted) begin
            nxt = (m_pc + 1) % 256;
            if (op < 16) m_pc = nxt;
            else begin
                case (op)
                    19: m_pc = int'(opnd);
                    20: m_pc = z ? int'(opnd) : nxt;
                    21: m_pc = z ? nxt : int'(opnd);
                    22: if (m_stk.size() == 4) begin m_err = 1'b1; m_halted = 1'b1; end
                        else begin m_stk.push_back(nxt); m_pc = int'(opnd); end
                    23: if (m_stk.size() == 0) begin m_err = 1'b1; m_halted = 1'b1; end
                        else m_pc = m_stk.pop_back();
                    24: m_halted = 1'b1;
                    default: m_pc = nxt;
                endcase
            end
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [4:0] r_opc;
        repeat (2) @(posedge CLK);
        #1;

        // Reset has priority over a live ALU op
        step(5'b00001, C_MODE_IMM, 8'h05, 1'b0, 1'b1, 1'b1);
        chk("rst_en_acc", 32'(EN_ACC), 32'd0);
        chk("rst_pc", 32'(PC), 32'd0);

        step(5'b00001, C_MODE_IMM, 8'h05, 1'b0, 1'b1, 1'b0);
        chk("alu_en_acc", 32'(EN_ACC), 32'd1);
        chk("alu_func", 32'(ALU_OUT), 32'd1);
        chk("alu_pc", 32'(PC), 32'h01);

        step(ctl(C_CTL_JZ), C_MODE_IMM, 8'h40, 1'b1, 1'b1, 1'b0);
        chk("jz_taken_pc", 32'(PC), 32'h40);
        step(ctl(C_CTL_JMP), C_MODE_IMM, 8'h10, 1'b0, 1'b1, 1'b0);
        step(ctl(C_CTL_JZ), C_MODE_IMM, 8'h40, 1'b0, 1'b1, 1'b0);
        chk("jz_not_taken_pc", 32'(PC), 32'h11);

        step(ctl(C_CTL_JMP), C_MODE_IMM, 8'h03, 1'b0, 1'b1, 1'b0);
        step(ctl(C_CTL_CALL), C_MODE_IMM, 8'h80, 1'b0, 1'b1, 1'b0);
        chk("call_pc", 32'(PC), 32'h80);
        step(ctl(C_CTL_RET), C_MODE_IMM, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("ret_pc", 32'(PC), 32'h04);
        step(ctl(C_CTL_RET), C_MODE_IMM, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("underflow_err", 32'(ERR), 32'd1);
        chk("underflow_pc", 32'(PC), 32'h04);
        step(5'b00010, C_MODE_IMM, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("halted_en_acc", 32'(EN_ACC), 32'd0);
        step(ctl(C_CTL_NOP), C_MODE_IMM, 8'h00, 1'b0, 1'b1, 1'b1);

        for (int i = 1; i <= 5; i++)
            step(ctl(C_CTL_CALL), C_MODE_IMM, 8'(i * 16), 1'b0, 1'b1, 1'b0);
        chk("overflow_err", 32'(ERR), 32'd1);
        chk("overflow_halted", 32'(HALTED), 32'd1);
        chk("overflow_pc", 32'(PC), 32'h40);
        step(ctl(C_CTL_STR), C_MODE_IMM, 8'h03, 1'b0, 1'b1, 1'b0);
        chk("overflow_en_reg_f", 32'(EN_REG_F), 32'd0);
        step(ctl(C_CTL_NOP), C_MODE_IMM, 8'h00, 1'b0, 1'b1, 1'b1);

        step(ctl(C_CTL_STM), C_MODE_MEMI, 8'h02, 1'b0, 1'b1, 1'b0);
        chk("stm_en_d_mem", 32'(EN_D_MEM), 32'd1);
        chk("stm_addr_mode", 32'(D_MEM_ADDR_MODE), 32'd1);
        chk("stm_in_b_sel", 32'(IN_B_SEL), 32'd2);
        step(ctl(C_CTL_STM), C_MODE_MEMI, 8'h02, 1'b0, 1'b0, 1'b0);
        chk("stall_en_d_mem", 32'(EN_D_MEM), 32'd0);
        chk("stall_pc", 32'(PC), 32'h01);

        step(ctl(C_CTL_JMP), C_MODE_IMM, 8'hFF, 1'b0, 1'b1, 1'b0);
        step(ctl(C_CTL_NOP), C_MODE_IMM, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("wrap_pc", 32'(PC), 32'h00);
        step(ctl(C_CTL_HALT), C_MODE_IMM, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("halt_halted", 32'(HALTED), 32'd1);
        chk("halt_pc", 32'(PC), 32'h00);
        step(ctl(C_CTL_NOP), C_MODE_IMM, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("halt_rst_halted", 32'(HALTED), 32'd0);
        chk("halt_rst_pc", 32'(PC), 32'h00);

        // Random programs: occasional stalls and resets, faster recovery from HALT
        for (int i = 0; i < 600; i++) begin
            r_opc = 5'($urandom_range(0, 31));
            step(r_opc, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 9) != 0,
                 ($urandom_range(0, 99) < 3) || (m_halted && $urandom_range(0, 4) == 0));
        end
        @(negedge CLK);
        chk("final_pc", 32'(PC), m_pc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
